// File: rtl/str_streamer_pkg.sv
// str_streamer_pkg: FSM state encoding and default terminator shared by the string streamer.
package str_streamer_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;
    localparam logic [7:0] TERM_DEF = 8'h00;
endpackage

// File: rtl/str_streamer_if.sv
// str_streamer_if: control, string-RAM read port and transmit handshake of the streamer.
interface str_streamer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] max_len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_dat;
    logic [DATA_W-1:0] tx_dat;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] count;
    modport master (
        input  start, base_addr, max_len, mem_dat, tx_ready,
        output mem_addr, mem_rd, tx_dat, tx_valid, busy, done, count
    );
    modport slave (
        output start, base_addr, max_len, mem_dat, tx_ready,
        input  mem_addr, mem_rd, tx_dat, tx_valid, busy, done, count
    );
endinterface

// File: rtl/str_streamer.sv
// str_streamer: reads a terminated string from RAM one byte at a time and offers each byte
// on a valid/ready stream, stopping at the terminator or after max_len accepted bytes.
module str_streamer
    import str_streamer_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter logic [DATA_W-1:0] TERM   = DATA_W'(TERM_DEF)
) (
    input logic               clk,
    input logic               rst,
    str_streamer_if.master    bus
);
    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] dat;
    logic              is_term;
    logic              hs;
    assign cnt_nx  = cnt + 1'b1;
    assign addr_nx = addr + 1'b1;
    assign is_term = bus.mem_dat == TERM;
    assign hs      = state == SEND && bus.tx_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.start ? (bus.max_len == '0 ? DONE : FETCH) : IDLE;
            FETCH:   next = WAIT;
            WAIT:    next = is_term ? DONE : SEND;
            SEND:    next = bus.tx_ready ? (cnt_nx == limit ? DONE : FETCH) : SEND;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    // Address wraps naturally at 2^ADDR_W; count holds after DONE until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr  <= '0;
            limit <= '0;
            cnt   <= '0;
            dat   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                addr  <= bus.base_addr;
                limit <= bus.max_len;
                cnt   <= '0;
            end
            if (state == WAIT && !is_term) dat <= bus.mem_dat;
            if (hs) begin
                addr <= addr_nx;
                cnt  <= cnt_nx;
            end
        end
    end
    always_comb begin
        bus.mem_addr = addr;
        bus.mem_rd   = state == FETCH;
        bus.tx_dat   = dat;
        bus.tx_valid = state == SEND;
        bus.busy     = state != IDLE;
        bus.done     = state == DONE;
        bus.count    = cnt;
    end
endmodule

// File: doc/str_streamer.md
STR_STREAMER -- requirements
Module: str_streamer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set byte width of memory data and transmit data.
REQ-002 Parameter ADDR_W, default 8, SHALL set string-RAM address width.
REQ-003 Parameter TERM, default 8'h00, SHALL set the string terminator byte.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 start  in  1  SHALL request a string transfer, sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  SHALL give the first string address, latched with start.
REQ-008 max_len  in  ADDR_W  SHALL give the maximum bytes to send, latched with start.
REQ-009 mem_addr  out  ADDR_W  SHALL drive the string-RAM read address.
REQ-010 mem_rd  out  1  SHALL strobe a RAM read for one cycle.
REQ-011 mem_dat  in  DATA_W  SHALL carry RAM read data, valid the cycle after mem_rd.
REQ-012 tx_dat  out  DATA_W  SHALL carry the byte offered downstream.
REQ-013 tx_valid  out  1  SHALL mark tx_dat valid.
REQ-014 tx_ready  in  1  SHALL indicate downstream acceptance.
REQ-015 busy  out  1  SHALL be high in every state except IDLE.
REQ-016 done  out  1  SHALL pulse high one cycle at transfer end.
REQ-017 count  out  ADDR_W  SHALL hold bytes accepted in current or last transfer.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, WAIT, SEND, DONE.
REQ-019 IDLE: start=1 SHALL latch base_addr into the address register, max_len into the limit register, clear count, and go to FETCH; if max_len=0 SHALL go to DONE instead.
REQ-020 FETCH: mem_rd=1 and mem_addr=address register for exactly one cycle, then WAIT.
REQ-021 WAIT: mem_dat=TERM SHALL go to DONE without asserting tx_valid; otherwise SHALL load tx_dat from mem_dat and go to SEND.
REQ-022 SEND: tx_valid=1 and tx_dat SHALL be held stable until tx_valid&&tx_ready.
REQ-023 On handshake: count SHALL increment, address SHALL increment modulo 2^ADDR_W (8'hFF -> 8'h00), and next state SHALL be DONE if the new count equals limit, else FETCH.
REQ-024 DONE: done=1 for one cycle, then IDLE; count SHALL hold until the next accepted start.
REQ-025 Latency: start sampled at edge N SHALL give mem_rd at N+1 and, for a non-terminator byte, tx_valid at N+3; minimum per-byte period 3 cycles with tx_ready held high.
REQ-026 start while busy SHALL be ignored; base_addr/max_len changes while busy SHALL have no effect.
REQ-027 tx_ready while tx_valid=0 SHALL have no effect.
REQ-028 mem_rd SHALL never be high outside FETCH; tx_valid SHALL never be high outside SEND.

Reset
REQ-029 rst low SHALL immediately force state IDLE, mem_addr=0, mem_rd=0, tx_dat=0, tx_valid=0, busy=0, done=0, count=0, regardless of an in-flight transfer.
REQ-030 After rst deassertion the block SHALL accept start on the first rising edge.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the TERM default constant.
REQ-032 The block SHALL be a single module with no sub-modules; the RAM model is instantiated only in the testbench.

Verification
REQ-033 RAM[0x10..0x13]="HI!",0x00, base=0x10, max_len=0x20, tx_ready=1 -> tx 0x48,0x49,0x21, done pulse, count=3.
REQ-034 Same string, max_len=2 -> tx 0x48,0x49 only, done, count=2, no read of 0x12.
REQ-035 base=0xFE, RAM[0xFE]=0x41, RAM[0xFF]=0x42, RAM[0x00]=0x00 -> tx 0x41,0x42, mem_addr wraps to 0x00, count=2.
REQ-036 tx_ready low 5 cycles during first byte -> tx_valid and tx_dat=0x48 stable all 5 cycles, no second mem_rd.
REQ-037 max_len=0 or RAM[base]=0x00 -> no tx_valid, done within 2 / 3 cycles of start, count=0.
REQ-038 rst low while in SEND -> all outputs to reset values same cycle; new start after release streams correctly.
